sdram_bridge32: RTL

Upstream neighbour of the `sdram` controller. Converts a single-outstanding 32-bit word bus (CPU or DMA master) into the controller's 16-bit burst read/write request interface. Holds a one-line, 8-word read buffer. Read hits complete without an SDRAM access; misses fill the whole line with one 16-halfword burst. Writes are write-through.

---
 rtl/sdram_bridge32.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_bridge32.sv
// 32-bit single-outstanding word bus to 16-bit SDRAM burst request bridge.
// One 8-word read line buffer; reads hit locally or refill the line, writes go straight through.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a bus request (ignored during the bus_ack cycle)
// S_RD_REQ  | line refill burst requested, waiting for rd_ack
// S_RD_FILL | collecting 16 halfwords into the line buffer
// S_ACK_RD  | registered lookup hit, return the buffered word
// S_WR      | write-through of two halfwords, waiting for two wr_ack
module sdram_bridge32 #(
   parameter int AWIDTH = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] bus_addr,
   input  logic [31:0]       bus_wdata,
   input  logic              bus_wr,
   input  logic              bus_req,
   output logic              bus_ack,
   output logic [31:0]       bus_rdata,
   output logic [AWIDTH:0]   rd_addr,
   output logic [3:0]        rd_len,
   output logic              rd_req,
   input  logic              rd_ack,
   input  logic [15:0]       rd_data,
   input  logic              rd_rdy,
   output logic [AWIDTH:0]   wr_addr,
   output logic [3:0]        wr_len,
   output logic [15:0]       wr_data,
   output logic              wr_req,
   input  logic              wr_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_FILL,
      S_ACK_RD,
      S_WR
   } state_t;

   state_t            state, state_nxt;
   logic [31:0]       line_mem [8];
   logic [AWIDTH-4:0] tag, tag_nxt;
   logic              valid, valid_nxt;
   logic [3:0]        beat, beat_nxt;
   logic              wr_second, wr_second_nxt;
   logic              bus_ack_nxt;
   logic [31:0]       bus_rdata_nxt;
   logic              rd_req_nxt;
   logic [AWIDTH:0]   rd_addr_nxt;
   logic              wr_req_nxt;
   logic [AWIDTH:0]   wr_addr_nxt;
   logic [15:0]       wr_data_nxt;
   logic              fill_we;
   logic              upd_we;
   logic              hit;
   logic [2:0]        word_sel;
   logic [31:0]       fill_word;

   assign word_sel = bus_addr[2:0];
   assign hit      = valid && (tag == bus_addr[AWIDTH-1:3]);
   assign rd_len   = 4'd15;
   assign wr_len   = 4'd1;

   // The last beat is still on rd_data when the fill completes, so word 7 is assembled here.
   assign fill_word = (word_sel == 3'd7) ? {rd_data, line_mem[7][15:0]} : line_mem[word_sel];

   always_comb begin
      state_nxt     = state;
      bus_ack_nxt   = 1'b0;
      bus_rdata_nxt = bus_rdata;
      rd_req_nxt    = rd_req;
      rd_addr_nxt   = rd_addr;
      wr_req_nxt    = wr_req;
      wr_addr_nxt   = wr_addr;
      wr_data_nxt   = wr_data;
      valid_nxt     = valid;
      tag_nxt       = tag;
      beat_nxt      = beat;
      wr_second_nxt = wr_second;
      fill_we       = 1'b0;
      upd_we        = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus_req && !bus_ack) begin
               if (bus_wr) begin
                  wr_req_nxt    = 1'b1;
                  wr_addr_nxt   = {bus_addr, 1'b0};
                  wr_data_nxt   = bus_wdata[15:0];
                  wr_second_nxt = 1'b0;
                  state_nxt     = S_WR;
               end else if (hit) begin
                  state_nxt = S_ACK_RD;
               end else begin
                  valid_nxt   = 1'b0;
                  rd_req_nxt  = 1'b1;
                  rd_addr_nxt = {bus_addr[AWIDTH-1:3], 4'b0000};
                  state_nxt   = S_RD_REQ;
               end
            end
         end
         S_RD_REQ: begin
            if (rd_ack) begin
               rd_req_nxt = 1'b0;
               beat_nxt   = 4'd0;
               state_nxt  = S_RD_FILL;
            end
         end
         S_RD_FILL: begin
            if (rd_rdy) begin
               fill_we  = 1'b1;
               beat_nxt = beat + 4'd1;
               // Completion acks directly so bus_ack follows the last beat by one cycle.
               if (beat == 4'd15) begin
                  valid_nxt     = 1'b1;
                  tag_nxt       = bus_addr[AWIDTH-1:3];
                  bus_ack_nxt   = 1'b1;
                  bus_rdata_nxt = fill_word;
                  state_nxt     = S_IDLE;
               end
            end
         end
         S_ACK_RD: begin
            bus_ack_nxt   = 1'b1;
            bus_rdata_nxt = line_mem[word_sel];
            state_nxt     = S_IDLE;
         end
         S_WR: begin
            if (wr_ack) begin
               if (!wr_second) begin
                  wr_data_nxt   = bus_wdata[31:16];
                  wr_second_nxt = 1'b1;
               end else begin
                  wr_req_nxt  = 1'b0;
                  upd_we      = hit;
                  bus_ack_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         bus_ack   <= 1'b0;
         bus_rdata <= '0;
         rd_req    <= 1'b0;
         rd_addr   <= '0;
         wr_req    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         valid     <= 1'b0;
         tag       <= '0;
         beat      <= '0;
         wr_second <= 1'b0;
      end else begin
         state     <= state_nxt;
         bus_ack   <= bus_ack_nxt;
         bus_rdata <= bus_rdata_nxt;
         rd_req    <= rd_req_nxt;
         rd_addr   <= rd_addr_nxt;
         wr_req    <= wr_req_nxt;
         wr_addr   <= wr_addr_nxt;
         wr_data   <= wr_data_nxt;
         valid     <= valid_nxt;
         tag       <= tag_nxt;
         beat      <= beat_nxt;
         wr_second <= wr_second_nxt;
      end
   end

   // Line storage carries no reset; valid alone qualifies its contents.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_we) begin
            if (beat[0])
               line_mem[beat[3:1]][31:16] <= rd_data;
            else
               line_mem[beat[3:1]][15:0] <= rd_data;
         end
         if (upd_we)
            line_mem[word_sel] <= bus_wdata;
      end
   end

endmodule
